// File: rtl/jtdd_pkg.sv
// Shared definitions for the DD main-CPU / MCU communication block.
package jtdd_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_t;

  localparam logic [15:0] COM_BASE = 16'h8000;

endpackage

// File: rtl/jtframe_dual_ram.sv
// Dual-port RAM with registered read ports; a read of an address being written returns the old data.
module jtframe_dual_ram #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] data0,
  input  logic          we0,
  output logic [DW-1:0] q0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] data1,
  input  logic          we1,
  output logic [DW-1:0] q1
);

  logic [DW-1:0] mem [0:2**AW-1];

  // Port 0 is written last so it takes a same-address collision.
  always_ff @(posedge clk) begin
    if (we1) mem[addr1] <= data1;
    if (we0) mem[addr0] <= data0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q0 <= '0;
      q1 <= '0;
    end else begin
      q0 <= mem[addr0];
      q1 <= mem[addr1];
    end
  end

endmodule

// File: rtl/jtdd_mcu_com.sv
// MCU side of the DD main-CPU link: shared comm RAM, halt/bus-available handshake,
// NMI pulse towards the MCU and IRQ strobe towards the main CPU.
module jtdd_mcu_com
  import jtdd_pkg::*;
#(
  parameter int AW      = 9,
  parameter int NMI_LEN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen_main,
  input  logic          cen_mcu,
  input  logic [AW-1:0] main_addr,
  input  logic [7:0]    main_dout,
  input  logic          main_rnw,
  input  logic          com_cs,
  output logic [7:0]    main_ram,
  input  logic          mcu_halt,
  input  logic          mcu_nmi_set,
  output logic          mcu_ban,
  output logic          mcu_irqmain,
  input  logic [15:0]   mcu_addr,
  input  logic [7:0]    mcu_dout,
  input  logic          mcu_wr,
  output logic [7:0]    mcu_din,
  output logic          mcu_ram_cs,
  input  logic          mcu_lic,
  output logic          mcu_haltn,
  output logic          mcu_nmi,
  input  logic          mcu_port_irq
);

  localparam logic [15-AW:0] CS_HI = COM_BASE[15:AW];
  localparam int CW = $clog2(NMI_LEN + 1);
  localparam logic [CW-1:0] NMI_LOAD = CW'(NMI_LEN);

  logic          main_we, mcu_we;
  logic [1:0]    halt_sync;
  logic          halt_s;
  halt_state_t   state, next_state;
  logic          nmi_last;
  logic [CW-1:0] nmi_cnt;
  logic          port_last, irq_pend;

  assign mcu_ram_cs = mcu_addr[15:AW] == CS_HI;
  assign main_we    = com_cs & ~main_rnw & cen_main;
  // The MCU write is dropped when the main CPU hits the same byte on the same clk.
  assign mcu_we     = mcu_ram_cs & mcu_wr & cen_mcu &
                      ~(main_we && main_addr == mcu_addr[AW-1:0]);

  jtframe_dual_ram #(.AW(AW), .DW(8)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .addr0 (main_addr),
    .data0 (main_dout),
    .we0   (main_we),
    .q0    (main_ram),
    .addr1 (mcu_addr[AW-1:0]),
    .data1 (mcu_dout),
    .we1   (mcu_we),
    .q1    (mcu_din)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_sync <= 2'b00;
      state     <= RUN;
    end else begin
      halt_sync <= {halt_sync[0], mcu_halt};
      state     <= next_state;
    end
  end

  assign halt_s = halt_sync[1];

  // Releasing from HALTED is immediate so the bus is returned without waiting for cen_mcu.
  always_comb begin
    next_state = state;
    mcu_haltn  = 1'b1;
    mcu_ban    = 1'b0;
    case (state)
      RUN: begin
        if (cen_mcu && halt_s) next_state = DRAIN;
      end
      DRAIN: begin
        mcu_haltn = 1'b0;
        if (cen_mcu) begin
          if (!halt_s)      next_state = RUN;
          else if (mcu_lic) next_state = HALTED;
        end
      end
      HALTED: begin
        mcu_haltn = 1'b0;
        mcu_ban   = 1'b1;
        if (!halt_s) next_state = RUN;
      end
      default: next_state = RUN;
    endcase
  end

  // The NMI count is frozen while halted so the MCU still sees the full pulse after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_last <= 1'b0;
      nmi_cnt  <= '0;
    end else begin
      nmi_last <= mcu_nmi_set;
      if (mcu_nmi_set && !nmi_last)
        nmi_cnt <= NMI_LOAD;
      else if (cen_mcu && nmi_cnt != '0 && state != HALTED)
        nmi_cnt <= nmi_cnt - CW'(1);
    end
  end

  assign mcu_nmi = nmi_cnt != '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_last   <= 1'b1;
      irq_pend    <= 1'b0;
      mcu_irqmain <= 1'b0;
    end else begin
      mcu_irqmain <= 1'b0;
      if (cen_mcu) port_last <= mcu_port_irq;
      if (cen_main && irq_pend) begin
        mcu_irqmain <= 1'b1;
        irq_pend    <= 1'b0;
      end else if (cen_mcu && port_last && !mcu_port_irq) begin
        irq_pend <= 1'b1;
      end
    end
  end

endmodule
